// File: rtl/primitives_pkg.sv
// Shared primitive data types used across the datapath blocks.
package primitives_pkg;

  typedef logic signed [15:0] slogic16_t;
  typedef logic [7:0]         ulogic8_t;

endpackage

// File: rtl/sat_accumulator.sv
// Frame accumulator: sums signed 16-bit beats with saturation and presents one
// registered result per frame (ended by in_last or MAX_BEATS) on a valid/ready port.
module sat_accumulator
  import primitives_pkg::*;
#(
  parameter int MAX_BEATS = 255
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      in_valid,
  output logic      in_ready,
  input  slogic16_t in_data,
  input  logic      in_last,
  output logic      out_valid,
  input  logic      out_ready,
  output slogic16_t out_sum,
  output ulogic8_t  out_count,
  output logic      out_sat
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam ulogic8_t MAX_CNT = ulogic8_t'(MAX_BEATS);

  state_e    state_q, state_d;
  slogic16_t acc_q, acc_d;
  ulogic8_t  cnt_q, cnt_d;
  logic      sat_q, sat_d;
  slogic16_t out_sum_q, out_sum_d;
  ulogic8_t  out_count_q, out_count_d;
  logic      out_sat_q, out_sat_d;
  logic      in_ready_q, in_ready_d;
  logic      out_valid_q, out_valid_d;

  logic              accept;
  logic              xfer;
  logic              frame_end;
  logic signed [16:0] sum_wide;
  slogic16_t         sum_clamped;
  logic              clamp;

  assign accept = in_valid & in_ready_q;
  assign xfer   = out_valid_q & out_ready;

  // One extra bit catches overflow: bits 16 and 15 disagree only when the
  // true sum is outside the 16-bit range.
  always_comb begin
    sum_wide    = {acc_q[15], acc_q} + {in_data[15], in_data};
    clamp       = sum_wide[16] ^ sum_wide[15];
    sum_clamped = sum_wide[15:0];
    if (clamp) begin
      sum_clamped = sum_wide[16] ? 16'sh8000 : 16'sh7fff;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_sat_d   = out_sat_q;
    frame_end   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d     = in_data;
          cnt_d     = 8'd1;
          sat_d     = 1'b0;
          frame_end = in_last | (MAX_CNT == 8'd1);
          state_d   = ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d     = sum_clamped;
          cnt_d     = cnt_q + 8'd1;
          sat_d     = sat_q | clamp;
          frame_end = in_last | ((cnt_q + 8'd1) == MAX_CNT);
        end
      end
      HOLD: begin
        if (xfer) begin
          state_d     = IDLE;
          acc_d       = '0;
          cnt_d       = '0;
          sat_d       = 1'b0;
          out_sum_d   = '0;
          out_count_d = '0;
          out_sat_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The result registers load on the same edge that accepts the ending beat.
    if (frame_end) begin
      state_d     = HOLD;
      out_sum_d   = acc_d;
      out_count_d = cnt_d;
      out_sat_d   = sat_d;
    end
  end

  // Handshake flags are registered from the next state so neither depends
  // combinationally on the opposite port.
  assign in_ready_d  = (state_d != HOLD);
  assign out_valid_d = (state_d == HOLD);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_sat_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_sat_q   <= out_sat_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_sat_accumulator.sv
// Scoreboard bench for sat_accumulator: a reference frame model pushes expected
// results as beats are driven; a monitor pops and compares on each output transfer.
module tb_sat_accumulator;
  import primitives_pkg::*;

  localparam int MAXB = 4;

  logic      clk;
  logic      rst_n;
  logic      in_valid;
  logic      in_ready;
  slogic16_t in_data;
  logic      in_last;
  logic      out_valid;
  logic      out_ready;
  slogic16_t out_sum;
  ulogic8_t  out_count;
  logic      out_sat;

  sat_accumulator #(.MAX_BEATS(MAXB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_sat   (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_pushed = 0;
  int n_popped = 0;

  logic [24:0] exp_q[$];
  int m_acc = 0;
  int m_cnt = 0;
  bit m_sat = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model of one accepted beat; returns 1 when the beat ends a frame.
  function automatic bit model_beat(input int d, input bit last);
    int s;
    if (m_cnt == 0) begin
      m_acc = d;
      m_sat = 1'b0;
      m_cnt = 1;
    end else begin
      s = m_acc + d;
      if (s > 32767) begin
        s = 32767;
        m_sat = 1'b1;
      end else if (s < -32768) begin
        s = -32768;
        m_sat = 1'b1;
      end
      m_acc = s;
      m_cnt++;
    end
    if (last || m_cnt == MAXB) begin
      exp_q.push_back({16'(m_acc), 8'(m_cnt), m_sat});
      n_pushed++;
      m_cnt = 0;
      m_acc = 0;
      m_sat = 1'b0;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // Called at posedge+1 with the beat already driven; returns at posedge+1.
  task automatic wait_accept(input bit ended);
    int waitc = 0;
    @(negedge clk);
    while (!in_ready && waitc < 100) begin
      waitc++;
      @(negedge clk);
    end
    if (!in_ready) check("accept_timeout", 32'(waitc), 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    if (ended) begin
      @(negedge clk);
      check("latency_valid", 32'(out_valid), 1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_beat(input int d, input bit last);
    bit ended;
    ended    = model_beat(d, last);
    in_valid = 1'b1;
    in_data  = slogic16_t'(d);
    in_last  = last;
    wait_accept(ended);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 32'(exp_q.size()), 1);
        end else begin
          check("result", {out_sum, out_count, out_sat}, exp_q.pop_front());
          n_popped++;
        end
      end else if (!out_valid) begin
        check("idle_zero", {out_sum, out_count, out_sat}, 0);
      end
    end
  end

  initial begin
    int waitc;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst", 32'(in_ready), 1);
    check("rst_outputs", {out_valid, out_sum, out_count, out_sat}, 0);

    // Basic frame, saturation high, saturation low, single-beat frames.
    send_beat(100, 0); send_beat(-30, 0); send_beat(7, 1);
    send_beat(30000, 0); send_beat(5000, 0); send_beat(-1000, 1);
    send_beat(-32768, 0); send_beat(-1, 1);
    send_beat(1234, 1);
    send_beat(-5, 1);

    // MAX_BEATS forced end; the fifth sample opens the next frame.
    send_beat(1, 0); send_beat(2, 0); send_beat(3, 0); send_beat(4, 0);
    send_beat(5, 0); send_beat(6, 1);
    send_beat(20000, 0); send_beat(20000, 0); send_beat(-100, 0); send_beat(-100, 0);

    // Backpressure in HOLD with a beat pending on the input.
    out_ready = 1'b0;
    send_beat(1000, 0); send_beat(2000, 0); send_beat(3000, 1);
    in_valid = 1'b1;
    in_data  = slogic16_t'(9);
    in_last  = 1'b1;
    void'(model_beat(9, 1));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_in_ready", 32'(in_ready), 0);
      check("hold_stable", {out_valid, out_sum, out_count, out_sat}, {1'b1, 16'sd6000, 8'd3, 1'b0});
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("xfer_in_ready", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    wait_accept(1'b1);

    // Reset mid-frame discards the partial sum.
    send_beat(50, 0); send_beat(60, 0);
    #2;
    rst_n = 1'b0;
    m_cnt = 0; m_acc = 0; m_sat = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 0);
    check("midrst_outputs", {out_valid, out_sum, out_count, out_sat}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_beat(9, 1);

    // Reset while a result is held: it must never be transferred.
    out_ready = 1'b0;
    send_beat(777, 1);
    rst_n = 1'b0;
    exp_q.delete();
    n_pushed--;
    #1;
    check("holdrst_outputs", {out_valid, out_sum, out_count, out_sat}, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send_beat(3, 1);

    waitc = 0;
    while (exp_q.size() != 0 && waitc < 50) begin
      waitc++;
      @(negedge clk);
    end
    @(negedge clk);
    check("queue_drain", 32'(exp_q.size()), 0);
    check("result_count", 32'(n_popped), 32'(n_pushed));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
